instr_mem_loader: RTL

Parametrised instruction memory for the pipelined MIPS-style core, replacing the fixed, hard-coded program store. The program is loaded at run time over a valid/ready word stream, under a small load state machine. The IF stage then fetches through a registered, one-cycle-latency read port. The port flags misaligned or out-of-range PCs and returns a NOP (all-zero word) for them. While a load is in progress the block holds `busy` high, and the pipeline must freeze on it.

---
 rtl/instr_mem_loader_if.sv | 32 +++
 rtl/instr_mem_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// Load-stream and fetch-port bundle for the instruction memory.
// The memory is the slave; the pipeline and loader side is the master.
interface instr_mem_loader_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
);
    localparam int AW = $clog2(DEPTH);

    logic             load_start;
    logic [AW:0]      load_count;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             load_done;
    logic             busy;

    logic             fetch_req;
    logic [WIDTH-1:0] pc;
    logic             fetch_valid;
    logic [WIDTH-1:0] instruction;
    logic             fetch_fault;

    modport master (
        output load_start, load_count, load_valid, load_data, fetch_req, pc,
        input  load_ready, load_done, busy, fetch_valid, instruction, fetch_fault
    );

    modport slave (
        input  load_start, load_count, load_valid, load_data, fetch_req, pc,
        output load_ready, load_done, busy, fetch_valid, instruction, fetch_fault
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory with a registered, fault-checked fetch port.
//
// state | meaning
// IDLE  | fetches serviced; load_start opens a session
// LOAD  | load_ready high, one word accepted per load_valid cycle
// DONE  | loaded_len updated, load_done pulse, back to IDLE
module instr_mem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_target;
    logic [AW:0]      r_loaded_len;

    logic             r_fetch_valid;
    logic [WIDTH-1:0] r_instruction;
    logic             r_fetch_fault;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_load_ready;
    logic             w_load_done;
    logic             w_accept;
    logic             w_last;
    logic             w_start;
    logic [AW:0]      w_target_in;

    logic             w_serviced;
    logic [AW-1:0]    w_idx;
    logic             w_misalign;
    logic             w_out_range;
    logic             w_beyond;
    logic             w_fault;

    assign w_start     = (r_state == IDLE) && bus.load_start;
    assign w_target_in = (bus.load_count > DEPTH_W) ? DEPTH_W : bus.load_count;
    assign w_accept    = (r_state == LOAD) && bus.load_valid;
    assign w_last      = (r_wr_ptr == (r_target - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_start) begin
                    w_state_nxt = (w_target_in == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                w_load_ready = 1'b1;
                if (bus.load_valid && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_load_done = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Session bookkeeping; loaded_len drops to 0 at start so no fetch sees a half-written image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_target     <= '0;
            r_loaded_len <= '0;
        end else begin
            if (w_start) begin
                r_wr_ptr     <= '0;
                r_target     <= w_target_in;
                r_loaded_len <= '0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (r_state == DONE) begin
                r_loaded_len <= r_target;
            end
        end
    end

    // Storage is deliberately unreset; contents are gated by loaded_len instead.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.load_data;
        end
    end

    assign w_serviced  = (r_state == IDLE) && !bus.load_start && bus.fetch_req;
    assign w_idx       = bus.pc[AW+1:2];
    assign w_misalign  = |bus.pc[1:0];
    assign w_out_range = |(bus.pc >> (AW + 2));
    assign w_beyond    = ({1'b0, w_idx} >= r_loaded_len);
    assign w_fault     = w_misalign || w_out_range || w_beyond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_instruction <= '0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_fetch_valid <= w_serviced;
            if (w_serviced) begin
                r_fetch_fault <= w_fault;
                r_instruction <= w_fault ? '0 : r_mem[w_idx];
            end
        end
    end

    assign bus.load_ready  = w_load_ready;
    assign bus.load_done   = w_load_done;
    assign bus.busy        = (r_state != IDLE);
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.instruction = r_instruction;
    assign bus.fetch_fault = r_fetch_fault;
endmodule
